// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential single-precision divider (q = a / b).
// Radix-2 restoring mantissa division, one quotient bit per clock.
// The result format follows FP_Mul: the mantissa is truncated, there is no
// rounding, and NaN and denormal operands are not handled.
// A zero dividend or a zero divisor exponent skips the divide loop.
module fp_div_seq #(
    parameter int         P      = 32,
    parameter logic [7:0] biasSP = 8'd127
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [P-1:0] a,
    input  logic [P-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [P-1:0] q
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [24:0]  rem_q, rem_d;
    logic [23:0]  mb_q, mb_d;
    logic [24:0]  qr_q, qr_d;
    // Only the low 8 bits of the 10-bit exponent difference reach q, and
    // they are the same whether the sum is formed on 8 or 10 bits.
    logic [7:0]   exp_q, exp_d;
    logic         sign_q, sign_d;
    logic         zero_q, zero_d;
    logic         inf_q, inf_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [P-1:0] q_q, q_d;

    logic         ge_s;
    logic [24:0]  diff_s;
    logic [24:0]  step_s;

    // One restoring step: subtract the divisor when it fits, keep the remainder otherwise.
    always_comb begin
        ge_s   = (rem_q >= {1'b0, mb_q});
        diff_s = rem_q - {1'b0, mb_q};
        if (ge_s) begin
            step_s = diff_s;
        end else begin
            step_s = rem_q;
        end
    end

    // Next-state logic for the controller and the datapath registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        mb_d    = mb_q;
        qr_d    = qr_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        inf_d   = inf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        q_d     = q_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mb_d   = {1'b1, b[22:0]};
                    rem_d  = {2'b00, a[22:0]} | 25'h0800000;
                    sign_d = a[31] ^ b[31];
                    exp_d  = a[30:23] - b[30:23] + biasSP;
                    cnt_d  = 5'd24;
                    qr_d   = 25'd0;
                    busy_d = 1'b1;
                    zero_d = (a[30:23] == 8'd0);
                    inf_d  = (a[30:23] != 8'd0) && (b[30:23] == 8'd0);
                    if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) begin
                        state_d = ST_NORM;
                    end else begin
                        state_d = ST_DIV;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                qr_d  = {qr_q[23:0], ge_s};
                rem_d = {step_s[23:0], 1'b0};
                if (cnt_q == 5'd0) begin
                    state_d = ST_NORM;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_NORM: begin
                if (zero_q) begin
                    q_d = {sign_q, 31'd0};
                end else if (inf_q) begin
                    q_d = {sign_q, 8'hFF, 23'd0};
                end else if (qr_q[24]) begin
                    q_d = {sign_q, exp_q, qr_q[23:1]};
                end else begin
                    // Quotient below 1.0: take one more bit and drop the exponent by one.
                    q_d = {sign_q, exp_q - 8'd1, qr_q[22:0]};
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset that discards any in-flight divide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 25'd0;
            mb_q    <= 24'd0;
            qr_q    <= 25'd0;
            exp_q   <= 8'd0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            inf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= {P{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            mb_q    <= mb_d;
            qr_q    <= qr_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            inf_q   <= inf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed cases, reset abort,
// back-to-back operation and randomized operands against an arithmetic model.
module tb_fp_div_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] q;

    int n_vec;
    int n_err;

    fp_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: quotient = floor(ma * 2^24 / mb), normalised by plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        logic [47:0] num;
        logic [47:0] den;
        logic [47:0] quo;
        int          e;
        logic [31:0] ev;
        s = x[31] ^ y[31];
        if (x[30:23] == 8'd0) return {s, 31'd0};
        if (y[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
        num = {1'b1, x[22:0], 24'd0};
        den = {24'd0, 1'b1, y[22:0]};
        quo = num / den;
        e = int'(x[30:23]) - int'(y[30:23]) + 127;
        if (quo >= 48'h1000000) begin
            ev = e;
            return {s, ev[7:0], quo[23:1]};
        end else begin
            e = e - 1;
            ev = e;
            return {s, ev[7:0], quo[22:0]};
        end
    endfunction

    // Wait (bounded) for done after the start edge; returns edges counted.
    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        while (!done && lat < limit) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Issue one divide and check latency, result, busy/done behaviour.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
        int lat;
        int want_lat;
        want_lat = ((x[30:23] == 8'd0) || (y[30:23] == 8'd0)) ? 1 : 26;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(40, lat);
        chk({tag, "_lat"}, lat, want_lat);
        chk({tag, "_q"}, q, ref_div(x, y));
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, "_q_hold"}, q, ref_div(x, y));
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] ra;
        logic [31:0] rb;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = 32'd0;
        b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", q, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases with hand-derived values.
        run_op("t1", 32'h40C00000, 32'h40000000);
        chk("t1_const", q, 32'h40400000);
        run_op("t2", 32'h3F800000, 32'h40400000);
        chk("t2_const", q, 32'h3EAAAAAA);
        run_op("t3", 32'hC0F00000, 32'h40200000);
        chk("t3_const", q, 32'hC0400000);
        run_op("t4_inf", 32'h3F800000, 32'h00000000);
        chk("t4_inf_const", q, 32'h7F800000);
        run_op("t4_zero", 32'h00000000, 32'h40000000);
        chk("t4_zero_const", q, 32'h00000000);
        run_op("t4_both", 32'h80000000, 32'h00000000);

        // Reset mid-division: no done, outputs cleared, then a clean T1.
        a = 32'h40C00000;
        b = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        a = 32'h3F800000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_q", q, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("t5_no_done", seen, 32'd0);
        run_op("t5_again", 32'h40C00000, 32'h40000000);

        // Back-to-back with start held high; operands change mid-operation.
        a = 32'h40C00000;
        b = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h3F800000;
        b = 32'h40400000;
        wait_done(40, lat);
        chk("t6_lat1", lat, 32'd26);
        chk("t6_q1", q, 32'h40400000);
        wait_done(0, lat);
        @(posedge clk);
        #1;
        wait_done(40, lat);
        chk("t6_lat2", lat + 1, 32'd27);
        chk("t6_q2", q, 32'h3EAAAAAA);
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        // Randomized operands, with occasional zero exponents.
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 15) == 0) ra[30:23] = 8'd0;
            if ($urandom_range(0, 15) == 0) rb[30:23] = 8'd0;
            run_op("rnd", ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
